// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm sweep controller.
//   VEC_W / NUM_VEC      : input vector width and number of vectors swept
//   CNT_W / ERR_W        : settle counter and error counter widths
//   DEFAULT_MINTERM_MASK : expected truth table, bit k = F(WXYZ = k)
//   state_e              : sweep FSM states
package minterm_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ERR_W   = 5;

  localparam logic [NUM_VEC-1:0] DEFAULT_MINTERM_MASK = 16'hDF03;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/minterm_sweep_ctrl_if.sv
// Start/status handshake plus datapath stimulus/response for the sweep controller.
//   slave  : controller view (takes start/abort/f_in, drives wxyz and status)
//   master : host/datapath view (drives start/abort/f_in, observes the rest)
interface minterm_sweep_ctrl_if;
  import minterm_pkg::*;

  logic                 start;
  logic                 abort;
  logic                 f_in;
  logic [VEC_W-1:0]     wxyz;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_VEC-1:0]   truth;
  logic [ERR_W-1:0]     err_count;
  logic [VEC_W-1:0]     first_err_idx;
  logic                 err_valid;

  modport slave (
    input  start, abort, f_in,
    output wxyz, busy, done, pass, truth, err_count, first_err_idx, err_valid
  );

  modport master (
    output start, abort, f_in,
    input  wxyz, busy, done, pass, truth, err_count, first_err_idx, err_valid
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long a vector has been held.
//   clk, rst_n   : clock, synchronous active-low reset
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : reload value
//   dec_i        : decrement, stops at zero
//   zero_c_o     : counter is zero (decode of the count register)
module settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_c_o
);

  logic [W-1:0] cnt_q;

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Self-checking sweep of a 4-input minterm function: drives all 16 vectors in
// ascending order, samples f_in after SETTLE_CYCLES+1 cycles per vector, builds
// the captured truth table and compares it against MINTERM_MASK.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : start/abort/f_in in; wxyz, busy, done, pass, truth,
//                err_count, first_err_idx, err_valid out (all registered)
module minterm_sweep_ctrl
  import minterm_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] MINTERM_MASK  = DEFAULT_MINTERM_MASK,
  parameter int unsigned        SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  minterm_sweep_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_IDX      = VEC_W'(NUM_VEC - 1);

  state_e               state_q, state_d;
  logic [VEC_W-1:0]     idx_q, idx_d;
  logic [VEC_W-1:0]     wxyz_q, wxyz_d;
  logic [NUM_VEC-1:0]   truth_q, truth_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic [VEC_W-1:0]     first_q, first_d;
  logic                 err_valid_q, err_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  logic                 tmr_load;
  logic                 tmr_dec;
  logic                 tmr_zero;

  settle_timer #(.W(CNT_W)) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_RELOAD),
    .dec_i      (tmr_dec),
    .zero_c_o   (tmr_zero)
  );

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wxyz_q      <= '0;
      truth_q     <= '0;
      err_cnt_q   <= '0;
      first_q     <= '0;
      err_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wxyz_q      <= wxyz_d;
      truth_q     <= truth_d;
      err_cnt_q   <= err_cnt_d;
      first_q     <= first_d;
      err_valid_q <= err_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state, sweep index, capture and compare
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wxyz_d      = wxyz_q;
    truth_d     = truth_q;
    err_cnt_d   = err_cnt_q;
    first_d     = first_q;
    err_valid_d = err_valid_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // abort is ignored here, so start always wins when both are high
        if (bus.start) begin
          state_d     = SETTLE;
          idx_d       = '0;
          wxyz_d      = '0;
          truth_d     = '0;
          err_cnt_d   = '0;
          first_d     = '0;
          err_valid_d = 1'b0;
          tmr_load    = 1'b1;
        end
      end

      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
          wxyz_d  = '0;
        end else if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
          wxyz_d  = '0;
        end else begin
          truth_d[idx_q] = bus.f_in;
          if (bus.f_in != MINTERM_MASK[idx_q]) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
            if (!err_valid_q) begin
              err_valid_d = 1'b1;
              first_d     = idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d    = idx_q + VEC_W'(1);
            wxyz_d   = idx_q + VEC_W'(1);
            tmr_load = 1'b1;
            state_d  = SETTLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Status flags: busy follows the next state; done/pass assert one cycle
  // after DONE is entered and drop on the restart edge.
  always_comb begin
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_q == DONE) && (state_d == DONE);
    pass_d = done_d && (err_cnt_q == '0);
  end

  assign bus.wxyz          = wxyz_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.truth         = truth_q;
  assign bus.err_count     = err_cnt_q;
  assign bus.first_err_idx = first_q;
  assign bus.err_valid     = err_valid_q;

endmodule

// File: doc/minterm_sweep_ctrl.md
# minterm_sweep_ctrl

Sequencer that exhaustively exercises the 4-input W,X,Y,Z minterm function block. It drives all 16 input vectors in ascending order, samples the function output after a programmable settle time and builds a 16-bit captured truth table. It compares the captured table against an expected minterm mask and reports pass/fail plus error details. It sits between a start/status interface and the combinational function datapath, replacing the open-loop stimulus sweep with a self-checking hardware sweep.

## Interface
- MINTERM_MASK, 16'hDF03, expected truth table; bit k = F for WXYZ = k (m(0,1,8,9,10,11,12,14,15))
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin sweep; honoured only in IDLE or DONE
- abort  input  1  cancel sweep; honoured only while busy
- f_in  input  1  function output from the datapath
- wxyz  output  4  drive to datapath; wxyz[3]=W … wxyz[0]=Z
- busy  output  1  high in SETTLE and SAMPLE
- done  output  1  high in DONE
- pass  output  1  valid when done; 1 iff err_count == 0
- truth  output  16  captured table; bit k = f_in sampled for vector k
- err_count  output  5  mismatches this sweep, 0..16
- first_err_idx  output  4  vector index of first mismatch
- err_valid  output  1  at least one mismatch captured this sweep

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 → SETTLE; idx←0, wxyz←0, settle counter←SETTLE_CYCLES-1, truth←0, err_count←0, err_valid←0, first_err_idx←0.
- SETTLE: counter decrements each cycle; on counter==0 → SAMPLE.
- SAMPLE: truth[idx]←f_in. If f_in != MINTERM_MASK[idx], increment err_count. On the first mismatch, also set err_valid←1 and first_err_idx←idx.
- SAMPLE exit: idx==15 → DONE. Otherwise idx←idx+1, wxyz←idx+1, counter reload, → SETTLE.
- DONE: done=1, pass=(err_count==0). Results held until start, which behaves as start from IDLE.
- abort in SETTLE/SAMPLE → IDLE next cycle. wxyz←0. truth and error outputs retain their partial values. done=0.
- abort and start in the same cycle: abort wins when busy; start wins in IDLE/DONE, where abort is ignored.
- start while busy is ignored.
- wxyz changes only on the SAMPLE→SETTLE edge or the start edge, never while settling.
- Reset values: state IDLE, wxyz 0, busy 0, done 0, pass 0, truth 0, err_count 0, first_err_idx 0, err_valid 0.
- Reset asserted mid-sweep returns everything to reset values at the next edge; no partial results are kept.
- err_count saturates naturally at 16; the 5-bit width is sufficient and no wrap can occur.
- idx wrap 15→0 never happens inside a sweep; DONE is entered instead.

## Timing
- Let S = SETTLE_CYCLES. start is sampled at edge 0. wxyz=0 is visible after edge 0.
- Vector k is held for S+1 cycles and sampled at edge (k+1)(S+1).
- done rises after edge 16(S+1)+1 (S=2: 49 cycles after start). busy is high for exactly 16(S+1) cycles.
- f_in must be stable S cycles after a wxyz change. The datapath is purely combinational, so S=1 suffices for a functional check.
- All outputs are registered. pass/err outputs update the same edge as the sample, and no output depends combinationally on inputs.

## Structure
- Shared package minterm_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - VEC_W=4 and NUM_VEC=16
  - DEFAULT_MINTERM_MASK=16'hDF03
- One sub-module is natural: settle_timer (load/decrement/zero flag, 4-bit).
- FSM, index, capture and compare logic stay in minterm_sweep_ctrl.
- The function block is instantiated alongside, not inside, this controller.

## Test plan
- Correct datapath, S=2, pulse start → done at cycle 49; truth=16'hDF03, err_count=0, err_valid=0, pass=1. wxyz steps 0..15 every 3 cycles.
- Datapath with output forced 0 → truth=16'h0000, err_count=9, first_err_idx=0, err_valid=1, pass=0.
- Datapath with vector 13 inverted (F(13)=1) → truth=16'hFF03, err_count=1, first_err_idx=13, pass=0.
- abort after vector 5 is sampled → IDLE next cycle, wxyz=0, busy=0, done=0, truth[5:0]=6'b000011. A new start then clears truth and completes normally.
- rst_n low for one cycle mid-sweep (vector 8) → all outputs at reset values next edge. start during busy has no effect, and sweep timing is unchanged.
- S=1 run, then start again from DONE → done at cycle 33 both times; second sweep results identical, err outputs cleared at the restart edge.
